hnoc_rr_arbiter: RTL and testbench

Round-robin arbiter that merges `NumIn` single-flit packet streams into one output port of the HNoC switch fabric. Each input and the output use the fabric's valid/ready handshake; a flit is `AddrWidth` destination bits concatenated above `DataWidth` payload bits. A one-entry registered output stage gives a full-throughput, single-cycle-latency path into the downstream router port or PE link.

---
 rtl/hnoc_pkg.sv | 17 +
 rtl/hnoc_rr_pick.sv | 36 +++
 rtl/hnoc_rr_arbiter.sv | 99 +++++++++
 tb/tb_hnoc_rr_arbiter.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/hnoc_pkg.sv
// Shared HNoC definitions: flit width helper, stats counter width, default flit layout.
package hnoc_pkg;

  localparam int StatsWidth   = 16;
  localparam int DefDataWidth = 32;
  localparam int DefAddrWidth = 3;

  function automatic int tw(input int data_width, input int addr_width);
    return data_width + addr_width;
  endfunction

  typedef struct packed {
    logic [DefAddrWidth-1:0] addr;
    logic [DefDataWidth-1:0] data;
  } flit_t;

endpackage

// File: rtl/hnoc_rr_pick.sv
// Combinational round-robin pick: first valid index scanning ptr, ptr+1, ... with explicit wrap.
module hnoc_rr_pick #(
  parameter int NumIn = 4,
  parameter int PtrW  = $clog2(NumIn)
) (
  input  logic [NumIn-1:0] valid,
  input  logic [PtrW-1:0]  ptr,
  output logic             found,
  output logic [PtrW-1:0]  grant
);

  logic [PtrW:0] idx;

  // Scan from the farthest offset down so the offset nearest ptr wins last.
  always_comb begin
    found = 1'b0;
    grant = {PtrW{1'b0}};
    idx   = {(PtrW+1){1'b0}};
    for (int i = NumIn - 1; i >= 0; i--) begin
      idx = {1'b0, ptr} + (PtrW+1)'(i);
      if (idx >= (PtrW+1)'(NumIn)) begin
        idx = idx - (PtrW+1)'(NumIn);
      end else begin
        idx = idx;
      end
      if (valid[idx[PtrW-1:0]]) begin
        found = 1'b1;
        grant = idx[PtrW-1:0];
      end else begin
        found = found;
        grant = grant;
      end
    end
  end

endmodule

// File: rtl/hnoc_rr_arbiter.sv
// NumIn-to-1 round-robin flit arbiter with a one-entry registered output stage.
// Optional per-requester saturating grant counters under HNOC_ARB_STATS_EN.
module hnoc_rr_arbiter
  import hnoc_pkg::*;
#(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 3,
  parameter int NumIn     = 4
) (
  input  logic                             i_clk,
  input  logic                             i_reset,
  input  logic [NumIn*tw(DataWidth,AddrWidth)-1:0] i_req_data,
  input  logic [NumIn-1:0]                 i_req_valid,
  output logic [NumIn-1:0]                 o_req_ready,
  output logic [tw(DataWidth,AddrWidth)-1:0] o_data,
  output logic                             o_data_valid,
  input  logic                             i_data_ready
`ifdef HNOC_ARB_STATS_EN
  ,
  output logic [NumIn*StatsWidth-1:0]      o_grant_cnt
`endif
);

  localparam int TW   = tw(DataWidth, AddrWidth);
  localparam int PtrW = $clog2(NumIn);

  logic [PtrW-1:0] ptr;
  logic [PtrW-1:0] grant;
  logic            found;
  logic            load;
  logic            xfer;

  hnoc_rr_pick #(
    .NumIn (NumIn),
    .PtrW  (PtrW)
  ) u_pick (
    .valid (i_req_valid),
    .ptr   (ptr),
    .found (found),
    .grant (grant)
  );

  assign load = !o_data_valid || i_data_ready;
  // No ready is issued during reset so nothing is accepted and then dropped.
  assign xfer = load && found && !i_reset;

  // One-hot ready toward the chosen requester.
  always_comb begin
    o_req_ready = {NumIn{1'b0}};
    if (xfer) begin
      o_req_ready[grant] = 1'b1;
    end else begin
      o_req_ready = {NumIn{1'b0}};
    end
  end

  // Output register and round-robin pointer.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_data       <= {TW{1'b0}};
      o_data_valid <= 1'b0;
      ptr          <= {PtrW{1'b0}};
    end else if (load) begin
      if (xfer) begin
        o_data       <= i_req_data[grant*TW +: TW];
        o_data_valid <= 1'b1;
        ptr          <= (grant == PtrW'(NumIn - 1)) ? {PtrW{1'b0}} : grant + PtrW'(1);
      end else begin
        o_data_valid <= 1'b0;
      end
    end else begin
      o_data       <= o_data;
      o_data_valid <= o_data_valid;
      ptr          <= ptr;
    end
  end

`ifdef HNOC_ARB_STATS_EN
  logic [StatsWidth-1:0] cnt [NumIn];

  // Saturating per-requester accepted-flit counters.
  always_ff @(posedge i_clk) begin
    for (int k = 0; k < NumIn; k++) begin
      if (i_reset) begin
        cnt[k] <= {StatsWidth{1'b0}};
      end else if (xfer && (grant == PtrW'(k)) && (cnt[k] != {StatsWidth{1'b1}})) begin
        cnt[k] <= cnt[k] + StatsWidth'(1);
      end else begin
        cnt[k] <= cnt[k];
      end
    end
  end

  for (genvar k = 0; k < NumIn; k++) begin : g_cnt
    assign o_grant_cnt[k*StatsWidth +: StatsWidth] = cnt[k];
  end
`endif

endmodule

// File: tb/tb_hnoc_rr_arbiter.sv
// Directed self-checking bench for hnoc_rr_arbiter (NumIn=4 and NumIn=3 instances).
module tb_hnoc_rr_arbiter;

  localparam int TW = 35;

  logic           clk = 1'b0;
  logic           rst;
  logic [4*TW-1:0] data4;
  logic [3:0]     valid4;
  logic [3:0]     ready4;
  logic [TW-1:0]  out4;
  logic           dv4;
  logic           dready4;
  logic [3*TW-1:0] data3;
  logic [2:0]     valid3;
  logic [2:0]     ready3;
  logic [TW-1:0]  out3;
  logic           dv3;
`ifdef HNOC_ARB_STATS_EN
  logic [4*16-1:0] cnt4;
  logic [3*16-1:0] cnt3;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hnoc_rr_arbiter #(.DataWidth(32), .AddrWidth(3), .NumIn(4)) dut4 (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_req_data   (data4),
    .i_req_valid  (valid4),
    .o_req_ready  (ready4),
    .o_data       (out4),
    .o_data_valid (dv4),
    .i_data_ready (dready4)
`ifdef HNOC_ARB_STATS_EN
    ,
    .o_grant_cnt  (cnt4)
`endif
  );

  hnoc_rr_arbiter #(.DataWidth(32), .AddrWidth(3), .NumIn(3)) dut3 (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_req_data   (data3),
    .i_req_valid  (valid3),
    .o_req_ready  (ready3),
    .o_data       (out3),
    .o_data_valid (dv3),
    .i_data_ready (1'b1)
`ifdef HNOC_ARB_STATS_EN
    ,
    .o_grant_cnt  (cnt3)
`endif
  );

  function automatic logic [TW-1:0] flit(input int k);
    return {3'(k), 32'hA000_0000 + 32'(k)};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst     = 1'b1;
    valid4  = 4'hF;
    valid3  = 3'b000;
    dready4 = 1'b1;
    for (int k = 0; k < 4; k++) data4[k*TW +: TW] = flit(k);
    for (int k = 0; k < 3; k++) data3[k*TW +: TW] = flit(k + 8);

    // Reset state, with requests pending
    tick();
    check("rst_ready", 64'(ready4), 64'h0);
    tick();
    check("rst_dv", 64'(dv4), 64'h0);
    check("rst_data", 64'(out4), 64'h0);
    check("rst_ready2", 64'(ready4), 64'h0);

    // All-request rotation 0,1,2,3,0,1
    rst = 1'b0;
    #1;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("rot_ready%0d", i), 64'(ready4), 64'(4'b0001 << (i % 4)));
      tick();
      check($sformatf("rot_dv%0d", i), 64'(dv4), 64'h1);
      check($sformatf("rot_data%0d", i), 64'(out4), 64'(flit(i % 4)));
    end

    // Back-pressure: output holds flit1, nothing accepted for 5 cycles
    dready4 = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_ready%0d", i), 64'(ready4), 64'h0);
      tick();
      check($sformatf("bp_data%0d", i), 64'(out4), 64'(flit(1)));
      check($sformatf("bp_dv%0d", i), 64'(dv4), 64'h1);
    end
    dready4 = 1'b1;
    #1;
    check("bp_resume_ready", 64'(ready4), 64'h4);
    tick();
    check("bp_resume_data", 64'(out4), 64'(flit(2)));

    // Single requester 2 with 0x1_DEADBEEF
    data4[2*TW +: TW] = 35'h1_DEAD_BEEF;
    valid4 = 4'b0100;
    #1;
    check("single_ready", 64'(ready4), 64'h4);
    tick();
    check("single_data", 64'(out4), 64'h1_DEAD_BEEF);
    check("single_dv", 64'(dv4), 64'h1);
    data4[2*TW +: TW] = flit(2);
    valid4 = 4'hF;
    #1;
    check("single_ptr3", 64'(ready4), 64'h8);
    tick();
    check("single_next_data", 64'(out4), 64'(flit(3)));

    // Idle load: valid drops, data holds
    valid4 = 4'b0000;
    #1;
    check("idle_ready", 64'(ready4), 64'h0);
    tick();
    check("idle_dv", 64'(dv4), 64'h0);
    check("idle_data", 64'(out4), 64'(flit(3)));

    // Reset mid-stream while a flit is held (ptr would be 2)
    valid4 = 4'b0010;
    tick();
    check("mid_pre_data", 64'(out4), 64'(flit(1)));
    dready4 = 1'b0;
    rst     = 1'b1;
    valid4  = 4'hF;
    #1;
    check("mid_rst_ready", 64'(ready4), 64'h0);
    tick();
    check("mid_rst_dv", 64'(dv4), 64'h0);
    check("mid_rst_data", 64'(out4), 64'h0);
    rst     = 1'b0;
    dready4 = 1'b1;
    valid4  = 4'b0110;
    #1;
    check("mid_first_ready", 64'(ready4), 64'h2);
    tick();
    check("mid_first_data", 64'(out4), 64'(flit(1)));
    valid4 = 4'b0000;

    // NumIn=3 wrap: bring ptr to 2, then request on 0 and 1
    valid3 = 3'b010;
    #1;
    check("w3_ready_g1", 64'(ready3), 64'h2);
    tick();
    check("w3_data_g1", 64'(out3), 64'(flit(9)));
    valid3 = 3'b011;
    #1;
    check("w3_wrap_g0", 64'(ready3), 64'h1);
    tick();
    check("w3_data_g0", 64'(out3), 64'(flit(8)));
    check("w3_ptr1", 64'(ready3), 64'h2);
    tick();
    check("w3_data_g1b", 64'(out3), 64'(flit(9)));
    check("w3_dv", 64'(dv3), 64'h1);
    valid3 = 3'b000;

`ifdef HNOC_ARB_STATS_EN
    rst = 1'b1;
    tick();
    check("st_clear", 64'(cnt4), 64'h0);
    rst    = 1'b0;
    valid4 = 4'b0010;
    for (int i = 0; i < 70000; i++) tick();
    valid4 = 4'b0000;
    tick();
    check("st_cnt1", 64'(cnt4[1*16 +: 16]), 64'hFFFF);
    check("st_cnt0", 64'(cnt4[0*16 +: 16]), 64'h0);
    check("st_cnt2", 64'(cnt4[2*16 +: 16]), 64'h0);
    check("st_cnt3", 64'(cnt4[3*16 +: 16]), 64'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
